ttt_host_sequencer: RTL and testbench

//  Host-side driver for the TickTockTokens pin protocol. Accepts commands over a valid/ready

---
 rtl/ttt_pkg.sv | 46 ++++
 rtl/ttt_tick_timer.sv | 53 +++++
 rtl/ttt_host_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ttt_host_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the TickTockTokens host sequencer: opcodes, the tally
// status reply layout and the sequencer FSM states.
package ttt_pkg;

    localparam int TTT_OP_BITS   = 4;
    localparam int TTT_DATA_BITS = 8;

    typedef enum logic [TTT_OP_BITS-1:0] {
        OP_ADD_GOOD     = 4'b0000,
        OP_ADD_BAD      = 4'b0001,
        OP_LOAD_A       = 4'b0010,
        OP_LOAD_B       = 4'b0011,
        OP_LOAD_C       = 4'b0100,
        OP_LOAD_D       = 4'b0101,
        OP_CFG_0        = 4'b0110,
        OP_CFG_1        = 4'b0111,
        OP_TALLY        = 4'b1000,
        OP_ADVANCE      = 4'b1001,
        OP_GET_GOOD     = 4'b1010,
        OP_GET_BAD      = 4'b1011,
        OP_GET_TOTAL    = 4'b1100,
        OP_GET_RATE     = 4'b1101,
        OP_GET_PEAK     = 4'b1110,
        OP_GET_DURATION = 4'b1111
    } ttt_op_e;

    typedef struct packed {
        logic [4:0] reserved;
        logic       valid;
        logic       start;
        logic       stop;
    } ttt_status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    // True when the opcode returns the status-format reply
    function automatic logic is_status_op(input logic [TTT_OP_BITS-1:0] op);
        return op == OP_TALLY;
    endfunction

endpackage

// File: rtl/ttt_tick_timer.sv
// Free-running auto-tick timer: raises tick_pending every TICK_PERIOD cycles
// and latches tick_overrun if a tick comes due before the last one was taken.
module ttt_tick_timer
    import ttt_pkg::*;
#(
    parameter int TICK_PERIOD   = 1000,
    parameter int TICK_CNT_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_clear,
    output logic tick_pending,
    output logic tick_overrun
);

    localparam logic [TICK_CNT_BITS-1:0] TICK_LAST = TICK_CNT_BITS'(TICK_PERIOD - 1);

    logic [TICK_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                     pending_q, pending_d;
    logic                     overrun_q, overrun_d;
    logic                     tick_due;

    // Counter wrap, pending set/clear and sticky overrun detection
    always_comb begin
        tick_due  = (cnt_q == TICK_LAST);
        cnt_d     = tick_due ? '0 : cnt_q + 1'b1;
        pending_d = pending_q;
        if (tick_clear) begin
            pending_d = 1'b0;
        end
        if (tick_due) begin
            pending_d = 1'b1;
        end
        overrun_d = overrun_q | (tick_due & pending_q & ~tick_clear);
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign tick_pending = pending_q;
    assign tick_overrun = overrun_q;

endmodule

// File: rtl/ttt_host_sequencer.sv
// Host-side driver for the TickTockTokens pin protocol. Takes commands on a
// valid/ready stream, holds each on the processor pins for RESP_LATENCY+1
// cycles, captures uo_out and returns it on the response stream.
// Optional feature macro: TTT_HOST_AUTOTICK_EN (periodic tally+advance).
module ttt_host_sequencer
    import ttt_pkg::*;
#(
    parameter int OP_BITS       = 4,
    parameter int DATA_BITS     = 8,
    parameter int RESP_LATENCY  = 1,
    parameter int TICK_PERIOD   = 1000,
    parameter int TICK_CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_BITS-1:0]   cmd_op,
    input  logic [DATA_BITS-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 rsp_is_status,
    output logic [OP_BITS-1:0]   pin_op,
    output logic [DATA_BITS-1:0] pin_data,
    input  logic [DATA_BITS-1:0] pin_rsp,
    output logic                 evt_start,
    output logic                 evt_stop,
    output logic                 tick_overrun
);

    localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [OP_BITS-1:0] TALLY_OP   = OP_BITS'(OP_TALLY);
    localparam logic [OP_BITS-1:0] ADVANCE_OP = OP_BITS'(OP_ADVANCE);

    seq_state_e           state_q, state_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 auto_q, auto_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_is_status_q, rsp_is_status_d;
    logic                 evt_start_q, evt_start_d;
    logic                 evt_stop_q, evt_stop_d;
    logic                 tick_pending;
    ttt_status_t          reply_status;

`ifdef TTT_HOST_AUTOTICK_EN
    logic tick_clear;

    // A pending tick is taken the moment the sequencer leaves IDLE for it
    assign tick_clear = (state_q == IDLE) && tick_pending;

    ttt_tick_timer #(
        .TICK_PERIOD   (TICK_PERIOD),
        .TICK_CNT_BITS (TICK_CNT_BITS)
    ) u_tick_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_clear   (tick_clear),
        .tick_pending (tick_pending),
        .tick_overrun (tick_overrun)
    );
`else
    assign tick_pending = 1'b0;
    assign tick_overrun = 1'b0;
`endif

    assign reply_status = ttt_status_t'(8'(pin_rsp));

    // State and datapath registers; reset drops any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            op_q            <= '0;
            data_q          <= '0;
            auto_q          <= 1'b0;
            cnt_q           <= '0;
            rsp_data_q      <= '0;
            rsp_is_status_q <= 1'b0;
            evt_start_q     <= 1'b0;
            evt_stop_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            data_q          <= data_d;
            auto_q          <= auto_d;
            cnt_q           <= cnt_d;
            rsp_data_q      <= rsp_data_d;
            rsp_is_status_q <= rsp_is_status_d;
            evt_start_q     <= evt_start_d;
            evt_stop_q      <= evt_stop_d;
        end
    end

    // Next-state: pick host or auto op, time the pin hold, capture the reply
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        data_d          = data_q;
        auto_d          = auto_q;
        cnt_d           = cnt_q;
        rsp_data_d      = rsp_data_q;
        rsp_is_status_d = rsp_is_status_q;
        evt_start_d     = 1'b0;
        evt_stop_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_pending) begin
                    op_d    = TALLY_OP;
                    data_d  = '0;
                    auto_d  = 1'b1;
                    state_d = ISSUE;
                end else if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    auto_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(RESP_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (is_status_op(4'(op_q)) && reply_status.valid) begin
                        evt_start_d = reply_status.start;
                        evt_stop_d  = reply_status.stop;
                    end
                    if (auto_q) begin
                        if (op_q == TALLY_OP) begin
                            op_d    = ADVANCE_OP;
                            state_d = ISSUE;
                        end else begin
                            auto_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        rsp_data_d      = pin_rsp;
                        rsp_is_status_d = is_status_op(4'(op_q));
                        state_d         = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: pins carry the op only while it is being issued or awaited
    always_comb begin
        cmd_ready = (state_q == IDLE) && !tick_pending;
        rsp_valid = (state_q == RESP);
        pin_op    = '0;
        pin_data  = '0;
        if ((state_q == ISSUE) || (state_q == WAIT)) begin
            pin_op   = op_q;
            pin_data = data_q;
        end
    end

    assign rsp_data      = rsp_data_q;
    assign rsp_is_status = rsp_is_status_q;
    assign evt_start     = evt_start_q;
    assign evt_stop      = evt_stop_q;

endmodule

// File: tb/tb_ttt_host_sequencer.sv
// Directed self-checking bench for ttt_host_sequencer (RESP_LATENCY=1).
// Host-only checks run in the default build; auto-tick checks run when
// TTT_HOST_AUTOTICK_EN is defined (TICK_PERIOD=8).
module tb_ttt_host_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_is_status;
    logic [3:0] pin_op;
    logic [7:0] pin_data;
    logic [7:0] pin_rsp = 8'h00;
    logic       evt_start;
    logic       evt_stop;
    logic       tick_overrun;
    logic [7:0] tally_reply = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    ttt_host_sequencer #(
        .OP_BITS       (4),
        .DATA_BITS     (8),
        .RESP_LATENCY  (1),
        .TICK_PERIOD   (8),
        .TICK_CNT_BITS (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_is_status (rsp_is_status),
        .pin_op        (pin_op),
        .pin_data      (pin_data),
        .pin_rsp       (pin_rsp),
        .evt_start     (evt_start),
        .evt_stop      (evt_stop),
        .tick_overrun  (tick_overrun)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Processor model with one cycle of latency: echoes data, or returns the
    // configured status byte for a tally op
    always @(posedge clk) begin
        pin_rsp <= (pin_op == 4'h8) ? tally_reply : pin_data;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the command channel
    task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [7:0] data);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_data  = data;
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence
    initial begin
        logic seen;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'h0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pin_op", 32'(pin_op), 32'h0);
        checkOutput("rst_pin_data", 32'(pin_data), 32'h00);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_evt_start", 32'(evt_start), 32'h0);
        checkOutput("rst_evt_stop", 32'(evt_stop), 32'h0);
        checkOutput("rst_overrun", 32'(tick_overrun), 32'h0);
        rst_n = 1'b1;
        tick();

`ifndef TTT_HOST_AUTOTICK_EN
        // Echo op: held 2 cycles, response 2 cycles after accept
        applyStimulus(1'b1, 4'h2, 8'h2A);
        checkOutput("t2_cmd_ready", 32'(cmd_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        checkOutput("t2_pin_op_c1", 32'(pin_op), 32'h2);
        checkOutput("t2_pin_data_c1", 32'(pin_data), 32'h2A);
        checkOutput("t2_busy_ready", 32'(cmd_ready), 32'h0);
        checkOutput("t2_rsp_early1", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t2_pin_op_c2", 32'(pin_op), 32'h2);
        checkOutput("t2_pin_data_c2", 32'(pin_data), 32'h2A);
        checkOutput("t2_rsp_early2", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t2_rsp_data", 32'(rsp_data), 32'h2A);
        checkOutput("t2_is_status", 32'(rsp_is_status), 32'h0);
        checkOutput("t2_pins_idle", 32'(pin_op), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("t2_rsp_done", 32'(rsp_valid), 32'h0);
        checkOutput("t2_ready_again", 32'(cmd_ready), 32'h1);

        // Tally reply 0x06: valid+start -> start pulse only, for one cycle
        tally_reply = 8'h06;
        applyStimulus(1'b1, 4'h8, 8'h00);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        tick();
        tick();
        checkOutput("t3_rsp_data", 32'(rsp_data), 32'h06);
        checkOutput("t3_is_status", 32'(rsp_is_status), 32'h1);
        checkOutput("t3_evt_start", 32'(evt_start), 32'h1);
        checkOutput("t3_evt_stop", 32'(evt_stop), 32'h0);
        tick();
        checkOutput("t3_evt_start_end", 32'(evt_start), 32'h0);
        checkOutput("t3_rsp_hold", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Tally reply 0x02: token_valid clear -> no pulses
        tally_reply = 8'h02;
        applyStimulus(1'b1, 4'h8, 8'h00);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        tick();
        tick();
        checkOutput("t3b_rsp_data", 32'(rsp_data), 32'h02);
        checkOutput("t3b_evt_start", 32'(evt_start), 32'h0);
        checkOutput("t3b_evt_stop", 32'(evt_stop), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Tally reply 0x05: valid+stop -> stop pulse only
        tally_reply = 8'h05;
        applyStimulus(1'b1, 4'h8, 8'h00);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        tick();
        tick();
        checkOutput("t3c_evt_start", 32'(evt_start), 32'h0);
        checkOutput("t3c_evt_stop", 32'(evt_stop), 32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Back-pressure: response held 5 cycles, new command refused, pins idle
        applyStimulus(1'b1, 4'h5, 8'h11);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        tick();
        tick();
        applyStimulus(1'b1, 4'h3, 8'h77);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("t4_rsp_data", 32'(rsp_data), 32'h11);
            checkOutput("t4_cmd_ready", 32'(cmd_ready), 32'h0);
            checkOutput("t4_pin_op", 32'(pin_op), 32'h0);
            checkOutput("t4_pin_data", 32'(pin_data), 32'h00);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 8'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("t4_released", 32'(cmd_ready), 32'h1);

        // Reset during WAIT aborts the op with no response
        applyStimulus(1'b1, 4'h2, 8'h33);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00);
        tick();
        checkOutput("t1_in_wait", 32'(pin_op), 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_pin_op", 32'(pin_op), 32'h0);
        checkOutput("t1_pin_data", 32'(pin_data), 32'h00);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_no_rsp", 32'(rsp_valid), 32'h0);
            checkOutput("t1_ready", 32'(cmd_ready), 32'h1);
            tick();
        end
        checkOutput("t1_overrun_tied", 32'(tick_overrun), 32'h0);
`else
        // Auto tick wins over a held host command: 8,8,9,9 then host op
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 4'h3, 8'h5C);
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            if (pin_op == 4'h8) begin
                seen = 1'b1;
            end else begin
                tick();
            end
        end
        checkOutput("t5_tick_seen", 32'(seen), 32'h1);
        checkOutput("t5_ready_blocked", 32'(cmd_ready), 32'h0);
        tick();
        checkOutput("t5_tally_c2", 32'(pin_op), 32'h8);
        tick();
        checkOutput("t5_adv_c1", 32'(pin_op), 32'h9);
        tick();
        checkOutput("t5_adv_c2", 32'(pin_op), 32'h9);
        tick();
        checkOutput("t5_idle_gap", 32'(pin_op), 32'h0);
        checkOutput("t5_idle_ready", 32'(cmd_ready), 32'h1);
        checkOutput("t5_no_auto_rsp", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t5_host_c1", 32'(pin_op), 32'h3);
        tick();
        checkOutput("t5_host_c2", 32'(pin_op), 32'h3);
        tick();
        checkOutput("t5_host_rsp", 32'(rsp_valid), 32'h1);
        checkOutput("t5_host_data", 32'(rsp_data), 32'h5C);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (rsp_valid) begin
                checkOutput("t5_rsp_host_only", 32'(rsp_is_status), 32'h0);
                checkOutput("t5_rsp_host_data", 32'(rsp_data), 32'h5C);
            end
        end
        checkOutput("t5_no_overrun", 32'(tick_overrun), 32'h0);

        // Stalled response channel lets a second tick come due -> sticky overrun
        rsp_ready = 1'b0;
        repeat (30) tick();
        checkOutput("t6_overrun", 32'(tick_overrun), 32'h1);
        rsp_ready = 1'b1;
        repeat (10) tick();
        checkOutput("t6_overrun_sticky", 32'(tick_overrun), 32'h1);
        applyStimulus(1'b0, 4'h0, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
